mmio_bus_bridge: RTL and testbench
==================================

Name: mmio_bus_bridge

Overview:
Parametrised successor to the fixed three-slave memory-map decoder used in the multi-cycle core. Sits between the core's memory port and N memory-mapped slaves (data RAM, instruction RAM, GPIO, future peripherals). Adds a valid/ready request handshake, multi-cycle slave wait states via per-slave ack, a bus timeout, and decode/alignment error reporting. The core stalls on req_ready.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
NUM_SLV, 3, number of slaves (1..8)
SLV_BASE, {32'h1001_0024, 32'h0040_0000, 32'h1001_0000}, packed NUM_SLV*ADDR_W base addresses; slave 0 in LSBs
SLV_MASK, {32'hFFFF_FFE0, 32'hFFFF_FF00, 32'hFFFF_FFE0}, packed NUM_SLV*ADDR_W match masks
TIMEOUT, 16, cycles to wait for ack before error (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
req_valid  in  1  core request valid; held until accepted
req_ready  out  1  bridge idle, request accepted when valid&ready
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  DATA_W  read data (0 on write or error)
rsp_err  out  1  qualifies rsp_valid: decode/align/timeout error
slv_sel  out  NUM_SLV  one-hot slave select
slv_we  out  1  write strobe to selected slave
slv_re  out  1  read strobe to selected slave
slv_addr  out  ADDR_W  word offset inside region: (addr & ~mask) >> 2
slv_wdata  out  DATA_W  latched write data
slv_rdata  in  NUM_SLV*DATA_W  packed slave read data
slv_ack  in  NUM_SLV  slave done; sampled only for the selected slave
err_addr  out  ADDR_W  address of last faulting request (see Optional Feature)

Behaviour:
- Reset (rst=0, async): state IDLE; req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0; slv_sel=0, slv_we=0, slv_re=0, slv_addr=0, slv_wdata=0; timeout counter 0; err_addr=0.
- States: IDLE, ACCESS, RESP_ERR.
- IDLE: req_ready=1. On req_valid, latch we/addr/wdata and decode. Hit = (req_addr & mask_i) == (base_i & mask_i). Lowest-index hit wins on overlap.
  - No hit, or req_addr[1:0] != 0: go to RESP_ERR.
  - Otherwise go to ACCESS; next cycle slv_sel[i]=1, slv_we/slv_re per latched we, counter=0.
- ACCESS: req_ready=0; strobes held stable.
  - On slv_ack[i]=1: next cycle rsp_valid=1, rsp_err=0; rsp_rdata = slave i data captured at ack (0 for writes); strobes and sel drop; return to IDLE.
  - If counter reaches TIMEOUT-1 without ack: same exit but rsp_err=1, rsp_rdata=0.
  - Ack and timeout in the same cycle: ack wins.
  - Acks from unselected slaves are ignored.
- RESP_ERR: one cycle with rsp_valid=1, rsp_err=1, rsp_rdata=0, no slave strobed; then IDLE.
- Latency: accept at cycle 0, strobes at cycle 1. Zero-wait slave (ack in cycle 1) gives rsp_valid at cycle 2. Error response at cycle 1.
- Back-to-back: req_ready returns 1 in the rsp_valid cycle; a new request can be accepted that cycle.
- req_valid while req_ready=0 is held off; not latched.
- Reset mid-access aborts with no response; slave strobes drop immediately.

Optional Feature:
BRIDGE_ERR_CAPTURE_EN
- Defined: err_addr loads the latched request address on every error response (decode, alignment or timeout), holds otherwise, and resets to 0.
- Undefined: err_addr is tied to 0 and no capture register is built.

Decomposition:
- Package mmio_bus_pkg holds the state enum {IDLE, ACCESS, RESP_ERR}, the error-cause constants, and the default base/mask localparams that form the system memory map.
- One combinational sub-module, mmio_addr_decode: inputs addr, SLV_BASE and SLV_MASK; outputs one-hot hit, hit index, miss and misaligned flags. The bridge FSM instantiates it.

Test Plan:
- Read 0x1001_0004, slave 0 acks in cycle 1 with 0xDEADBEEF -> slv_addr=1, rsp_valid at cycle 2, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Write 0x1001_0024 data 0x55 -> slv_sel=3'b100, slv_we=1, slv_wdata=0x55; slave 2 acks after 3 waits -> rsp_valid 1 cycle after ack, rsp_rdata=0.
- Read 0x2000_0000 (unmapped) -> rsp_valid=1, rsp_err=1 at cycle 1, slv_sel never asserted; err_addr=0x2000_0000 with macro, 0 without.
- Read 0x0040_0002 (misaligned) -> error response at cycle 1, no strobe.
- Selected slave never acks, TIMEOUT=16 -> rsp_err=1 exactly 16 cycles after strobe start; a stray ack on another slave in that window is ignored.
- Assert rst low mid-ACCESS -> all outputs 0 asynchronously, req_ready=1 after release, no rsp_valid emitted.

Source files
------------

// File: rtl/mmio_bus_pkg.sv
// mmio_bus_pkg: bridge FSM states, error causes, default memory map.
// Map: slave0 data RAM, slave1 instruction RAM, slave2 GPIO.
package mmio_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP_ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_DECODE,
    ERR_ALIGN,
    ERR_TIMEOUT
  } err_cause_e;

  localparam int MMIO_NUM_SLV = 3;

  localparam logic [3*32-1:0] MMIO_SLV_BASE = {
    32'h1001_0024, 32'h0040_0000, 32'h1001_0000
  };

  localparam logic [3*32-1:0] MMIO_SLV_MASK = {
    32'hFFFF_FFE0, 32'hFFFF_FF00, 32'hFFFF_FFE0
  };

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_addr_decode.sv
// mmio_addr_decode: combinational slave match, lowest index wins.
// Ports: addr_i in; hit_o one-hot, idx_o, miss_o, misal_o out.
module mmio_addr_decode
  import mmio_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NUM_SLV = 3,
  parameter int IDX_W = 2,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic [ADDR_W-1:0]  addr_i,
  output logic [NUM_SLV-1:0] hit_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               miss_o,
  output logic               misal_o
);

  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] mask;

  // Walk high to low so the lowest matching index overrides.
  always_comb begin
    hit_o = '0;
    idx_o = '0;
    base  = '0;
    mask  = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      base = SLV_BASE[i*ADDR_W +: ADDR_W];
      mask = SLV_MASK[i*ADDR_W +: ADDR_W];
      if ((addr_i & mask) == (base & mask)) begin
        hit_o    = '0;
        hit_o[i] = 1'b1;
        idx_o    = IDX_W'(i);
      end
    end
    miss_o  = (hit_o == '0);
    misal_o = |addr_i[1:0];
  end

endmodule

// File: rtl/mmio_bus_bridge.sv
// mmio_bus_bridge: core port to N MMIO slaves, wait states, timeout.
// Core req/rsp, slave sel/strobes/ack; BRIDGE_ERR_CAPTURE_EN adds err_addr.
module mmio_bus_bridge
  import mmio_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_SLV = MMIO_NUM_SLV,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = MMIO_SLV_BASE,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = MMIO_SLV_MASK,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [NUM_SLV-1:0]        slv_sel,
  output logic                      slv_we,
  output logic                      slv_re,
  output logic [ADDR_W-1:0]         slv_addr,
  output logic [DATA_W-1:0]         slv_wdata,
  input  logic [NUM_SLV*DATA_W-1:0] slv_rdata,
  input  logic [NUM_SLV-1:0]        slv_ack,
  output logic [ADDR_W-1:0]         err_addr
);

  localparam int IDX_W = idx_width(NUM_SLV);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e             state_q;
  err_cause_e         cause_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  logic [NUM_SLV-1:0] slv_sel_q;
  logic               slv_we_q;
  logic               slv_re_q;
  logic [ADDR_W-1:0]  slv_addr_q;
  logic [DATA_W-1:0]  slv_wdata_q;

  logic [NUM_SLV-1:0] dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic               dec_miss;
  logic               dec_misal;
  logic [ADDR_W-1:0]  mask_sel;
  logic [ADDR_W-1:0]  offset;
  logic               ack_sel;
  logic [DATA_W-1:0]  rdata_sel;

  mmio_addr_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_SLV  (NUM_SLV),
    .IDX_W    (IDX_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .addr_i  (req_addr),
    .hit_o   (dec_hit),
    .idx_o   (dec_idx),
    .miss_o  (dec_miss),
    .misal_o (dec_misal)
  );

  always_comb begin
    mask_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (dec_idx == IDX_W'(i)) mask_sel = SLV_MASK[i*ADDR_W +: ADDR_W];
    end
    offset = (req_addr & ~mask_sel) >> 2;
  end

  // Only the selected slave's ack and data are looked at.
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (slv_sel_q[i]) begin
        ack_sel   = slv_ack[i];
        rdata_sel = slv_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef BRIDGE_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] err_addr_q;
  assign err_addr = err_addr_q;
`else
  assign err_addr = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cause_q     <= ERR_NONE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      slv_sel_q   <= '0;
      slv_we_q    <= 1'b0;
      slv_re_q    <= 1'b0;
      slv_addr_q  <= '0;
      slv_wdata_q <= '0;
`ifdef BRIDGE_ERR_CAPTURE_EN
      addr_q      <= '0;
      err_addr_q  <= '0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      cause_q     <= ERR_NONE;
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            if (dec_miss || dec_misal) begin
              state_q     <= RESP_ERR;
              rsp_valid_q <= 1'b1;
              if (dec_miss) cause_q <= ERR_DECODE;
              else          cause_q <= ERR_ALIGN;
`ifdef BRIDGE_ERR_CAPTURE_EN
              err_addr_q  <= req_addr;
`endif
            end else begin
              state_q     <= ACCESS;
              slv_sel_q   <= dec_hit;
              slv_we_q    <= req_we;
              slv_re_q    <= ~req_we;
              slv_addr_q  <= offset;
              slv_wdata_q <= req_wdata;
              cnt_q       <= '0;
`ifdef BRIDGE_ERR_CAPTURE_EN
              addr_q      <= req_addr;
`endif
            end
          end
        end
        ACCESS: begin
          if (ack_sel || cnt_q == CNT_LAST) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b1;
            slv_sel_q   <= '0;
            slv_we_q    <= 1'b0;
            slv_re_q    <= 1'b0;
            // Ack beats a coincident timeout.
            if (ack_sel) begin
              rsp_rdata_q <= slv_we_q ? '0 : rdata_sel;
            end else begin
              cause_q    <= ERR_TIMEOUT;
`ifdef BRIDGE_ERR_CAPTURE_EN
              err_addr_q <= addr_q;
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP_ERR: state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = (cause_q != ERR_NONE);
  assign slv_sel   = slv_sel_q;
  assign slv_we    = slv_we_q;
  assign slv_re    = slv_re_q;
  assign slv_addr  = slv_addr_q;
  assign slv_wdata = slv_wdata_q;

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// tb_mmio_bus_bridge: directed checks of the MMIO bridge.
// Inputs driven and outputs sampled 1ns after each rising edge.
module tb_mmio_bus_bridge;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [2:0]  slv_sel;
  logic        slv_we;
  logic        slv_re;
  logic [31:0] slv_addr;
  logic [31:0] slv_wdata;
  logic [95:0] slv_rdata;
  logic [2:0]  slv_ack;
  logic [31:0] err_addr;

  int checks = 0;
  int errors = 0;

  mmio_bus_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .slv_sel   (slv_sel),
    .slv_we    (slv_we),
    .slv_re    (slv_re),
    .slv_addr  (slv_addr),
    .slv_wdata (slv_wdata),
    .slv_rdata (slv_rdata),
    .slv_ack   (slv_ack),
    .err_addr  (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  function automatic logic [31:0] exp_err_addr(input logic [31:0] a);
`ifdef BRIDGE_ERR_CAPTURE_EN
    return a;
`else
    return 32'h0 & a;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
    checks++;
    if ({rsp_valid, rsp_err, slv_we, slv_re, slv_sel} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b want 0",
               {rsp_valid, rsp_err, slv_we, slv_re, slv_sel});
    end
    checks++;
    if ({rsp_rdata, slv_addr, slv_wdata, err_addr} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0",
               {rsp_rdata, slv_addr, slv_wdata, err_addr});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_read_zero_wait();
    issue(1'b0, 32'h1001_0004, 32'h0);
    tick();
    req_valid = 1'b0;
    checks++;
    if ({req_ready, slv_sel, slv_re, slv_we, rsp_valid} !== 7'b0_001_1_0_0) begin
      errors++;
      $display("FAIL rd_strobe: got %b want 0001100",
               {req_ready, slv_sel, slv_re, slv_we, rsp_valid});
    end
    checks++;
    if (slv_addr !== 32'h1) begin
      errors++;
      $display("FAIL rd_slv_addr: got %h want 1", slv_addr);
    end
    slv_rdata[31:0] = 32'hDEAD_BEEF;
    slv_ack = 3'b001;
    tick();
    slv_ack = 3'b000;
    checks++;
    if ({rsp_valid, rsp_err, req_ready, slv_sel} !== 6'b1_0_1_000) begin
      errors++;
      $display("FAIL rd_rsp: got %b want 101000",
               {rsp_valid, rsp_err, req_ready, slv_sel});
    end
    checks++;
    if (rsp_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_rdata: got %h want deadbeef", rsp_rdata);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_pulse: got %b want 0", rsp_valid);
    end
  endtask

  task automatic test_write_wait();
    slv_rdata[95:64] = 32'hCAFE_F00D;
    issue(1'b1, 32'h1001_0024, 32'h55);
    tick();
    req_valid = 1'b0;
    checks++;
    if ({slv_sel, slv_we, slv_re} !== 5'b100_1_0) begin
      errors++;
      $display("FAIL wr_strobe: got %b want 10010",
               {slv_sel, slv_we, slv_re});
    end
    checks++;
    if ({slv_wdata, slv_addr} !== {32'h55, 32'h1}) begin
      errors++;
      $display("FAIL wr_data_addr: got %h want 0000005500000001",
               {slv_wdata, slv_addr});
    end
    for (int w = 0; w < 3; w++) begin
      tick();
      checks++;
      if ({rsp_valid, slv_sel, slv_we} !== 5'b0_100_1) begin
        errors++;
        $display("FAIL wr_wait%0d: got %b want 01001", w,
                 {rsp_valid, slv_sel, slv_we});
      end
    end
    slv_ack = 3'b100;
    tick();
    slv_ack = 3'b000;
    checks++;
    if ({rsp_valid, rsp_err, slv_sel, slv_we} !== 6'b1_0_000_0) begin
      errors++;
      $display("FAIL wr_rsp: got %b want 100000",
               {rsp_valid, rsp_err, slv_sel, slv_we});
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL wr_rdata: got %h want 0", rsp_rdata);
    end
    tick();
  endtask

  task automatic test_decode_error(input logic [31:0] a);
    issue(1'b0, a, 32'h0);
    tick();
    req_valid = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, slv_sel, slv_re, slv_we} !== 7'b1_1_000_0_0) begin
      errors++;
      $display("FAIL err_rsp %h: got %b want 1100000", a,
               {rsp_valid, rsp_err, slv_sel, slv_re, slv_we});
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL err_rdata %h: got %h want 0", a, rsp_rdata);
    end
    checks++;
    if (err_addr !== exp_err_addr(a)) begin
      errors++;
      $display("FAIL err_addr %h: got %h want %h", a, err_addr,
               exp_err_addr(a));
    end
    tick();
    checks++;
    if ({rsp_valid, req_ready, slv_sel} !== 5'b0_1_000) begin
      errors++;
      $display("FAIL err_after %h: got %b want 01000", a,
               {rsp_valid, req_ready, slv_sel});
    end
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    issue(1'b0, 32'h0040_0000, 32'h0);
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (rsp_valid !== 1'b0 || slv_sel !== 3'b010) bad++;
      slv_ack = (k == 5) ? 3'b101 : 3'b000;
      tick();
    end
    slv_ack = 3'b000;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL to_window: got %0d bad cycles want 0", bad);
    end
    checks++;
    if ({rsp_valid, rsp_err, slv_sel, slv_re} !== 6'b1_1_000_0) begin
      errors++;
      $display("FAIL to_rsp: got %b want 110000",
               {rsp_valid, rsp_err, slv_sel, slv_re});
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL to_rdata: got %h want 0", rsp_rdata);
    end
    checks++;
    if (err_addr !== exp_err_addr(32'h0040_0000)) begin
      errors++;
      $display("FAIL to_err_addr: got %h want %h", err_addr,
               exp_err_addr(32'h0040_0000));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 32'h1001_0008, 32'h0);
    tick();
    issue(1'b1, 32'h0040_0004, 32'hA5);
    slv_rdata[31:0] = 32'h1111_1111;
    slv_ack = 3'b001;
    checks++;
    if ({slv_sel, req_ready} !== 4'b001_0 || slv_addr !== 32'h2) begin
      errors++;
      $display("FAIL b2b_first: got sel %b rdy %b addr %h want 001 0 2",
               slv_sel, req_ready, slv_addr);
    end
    tick();
    slv_ack = 3'b000;
    checks++;
    if ({rsp_valid, rsp_err, req_ready} !== 3'b101 ||
        rsp_rdata !== 32'h1111_1111) begin
      errors++;
      $display("FAIL b2b_rsp1: got %b %h want 101 11111111",
               {rsp_valid, rsp_err, req_ready}, rsp_rdata);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if ({slv_sel, slv_we} !== 4'b010_1 || slv_addr !== 32'h1 ||
        slv_wdata !== 32'hA5) begin
      errors++;
      $display("FAIL b2b_second: got %b %h %h want 0101 1 a5",
               {slv_sel, slv_we}, slv_addr, slv_wdata);
    end
    slv_ack = 3'b010;
    tick();
    slv_ack = 3'b000;
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL b2b_rsp2: got %b %h want 10 0",
               {rsp_valid, rsp_err}, rsp_rdata);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    issue(1'b0, 32'h0040_0010, 32'h0);
    tick();
    req_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({slv_sel, slv_re, slv_we, rsp_valid, req_ready} !== 7'b000_0_0_0_1) begin
      errors++;
      $display("FAIL rst_mid: got %b want 0000001",
               {slv_sel, slv_re, slv_we, rsp_valid, req_ready});
    end
    slv_ack = 3'b010;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (rsp_valid !== 1'b0) seen++;
    end
    slv_ack = 3'b000;
    checks++;
    if (seen !== 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_after: got rsp %0d rdy %b want 0 1",
               seen, req_ready);
    end
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    slv_ack   = '0;
    slv_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_0000};
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_decode_error(32'h2000_0000);
    test_decode_error(32'h0040_0002);
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
